// File: rtl/seq_mult_16_pkg.sv
// Shared constants and state encoding for the sequential 16x16 multiplier.
package seq_mult_16_pkg;

  // Operand width; the datapath is built around a 16-bit adder.
  localparam int MULT_WIDTH = 16;

  // Index of the final add/shift iteration (16 iterations: 0..15).
  localparam logic [4:0] ITER_LAST = 5'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/CLA_16bit.sv
// 16-bit two-level carry-lookahead adder: four 4-bit lookahead groups
// chained through group generate/propagate terms.
module CLA_16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        C_In,
  output logic [15:0] Sum,
  output logic        C_Out
);

  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;
  logic [3:0]  gg;
  logic [3:0]  pg;

  assign g = A & B;
  assign p = A ^ B;

  // Carry network: group terms first, then carries inside each group.
  always_comb begin
    c    = '0;
    gg   = '0;
    pg   = '0;
    c[0] = C_In;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg[k] = &p[4*k +: 4];
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = gg[k] | (pg[k] & c[4*k]);
    end
  end

  assign Sum   = p ^ c[15:0];
  assign C_Out = c[16];

endmodule

// File: rtl/seq_mult_16.sv
// Sequential unsigned shift-and-add multiplier: one add/shift per clock,
// 16 iterations per operation, start/busy/done handshake.
module seq_mult_16
  import seq_mult_16_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH:0]   acc_q, acc_d;     // {carry, upper half, lower half}
  logic [4:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   cla_sum;
  logic               cla_cout;

  // The adder always sees the partial-product upper half and the multiplicand;
  // its result is only consumed when the current multiplier bit is 1.
  CLA_16bit u_cla (
    .A     (acc_q[2*WIDTH-1:WIDTH]),
    .B     (mcand_q),
    .C_In  (1'b0),
    .Sum   (cla_sum),
    .C_Out (cla_cout)
  );

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d = a;
          acc_d   = {{(WIDTH+1){1'b0}}, b};
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // The adder carry-out lands in the upper-half MSB after the shift;
        // losing it would corrupt products near 0xFFFF_xxxx.
        if (acc_q[0]) acc_d = {1'b0, cla_cout, cla_sum, acc_q[WIDTH-1:1]};
        else          acc_d = acc_q >> 1;  // bit 32 is always 0 here
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == ITER_LAST) begin
          product_d = acc_d[2*WIDTH-1:0];
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values together.
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_seq_mult_16.sv
// Directed self-checking bench for seq_mult_16.
module tb_seq_mult_16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  seq_mult_16 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Wait (at falling edges) for done; lat counts edges since the start edge.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Issue one start pulse and wait for completion.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, output int lat);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);           // E0 has sampled start
    start = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF;  // operands may change after capture
    wait_done(lat);
  endtask

  initial begin
    int lat;
    int seen_done;

    vecs[0] = '{16'd16,   16'd128,  32'd2048};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[2] = '{16'h8040, 16'd5,    32'h00028140};
    vecs[3] = '{16'h0000, 16'hFFFF, 32'h00000000};
    vecs[4] = '{16'h1234, 16'h0001, 32'h00001234};
    vecs[5] = '{16'd1000, 16'd3,    32'd3000};

    // Reset with random inputs applied.
    rst_n = 1'b0;
    start = 1'($urandom);
    a     = 16'($urandom);
    b     = 16'($urandom);
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", product, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
    end

    // Table-driven operations.
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat);
      check("latency", 32'(lat), 32'd16);
      check("product", product, vecs[i].exp);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("idle_after_done", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      check("product_hold", product, vecs[i].exp);
    end

    // start re-asserted through RUN and DONE is ignored; held start is
    // accepted at the first IDLE edge, giving done pulses 18 cycles apart.
    @(negedge clk);
    a = 16'd3; b = 16'd7; start = 1'b1;
    @(negedge clk);
    a = 16'd9; b = 16'd9;
    wait_done(lat);
    check("busy_start_latency", 32'(lat), 32'd16);
    check("busy_start_product", product, 32'd21);
    @(negedge clk);
    check("held_start_idle_busy", 32'(busy), 32'd0);
    check("held_start_idle_done", 32'(done), 32'd0);
    @(negedge clk);
    check("held_start_accepted", 32'(busy), 32'd1);
    check("held_start_old_product", product, 32'd21);
    wait_done(lat);
    start = 1'b0;
    check("held_start_latency", 32'(lat), 32'd16);
    check("held_start_product", product, 32'd81);
    @(negedge clk);

    // Reset in the middle of an operation.
    @(negedge clk);
    a = 16'd100; b = 16'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_op_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_product", product, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    check("no_done_after_rst", 32'(seen_done), 32'd0);
    run_op(16'd100, 16'd200, lat);
    check("post_rst_latency", 32'(lat), 32'd16);
    check("post_rst_product", product, 32'd20000);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
